// File: rtl/mux_nx1_rr_if.sv
// mux_nx1_rr_if -- bundle of the channel-merge handshake signals.
//   in_data  : CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid : per-channel valid      in_ready : per-channel ready (one-hot or zero)
//   mode     : 0 = manual via sel, 1 = round-robin
//   sel      : manual channel index
//   y/y_valid/y_ready/y_chan : registered output stream and its source channel
// master = producer/consumer side, slave = the mux.
interface mux_nx1_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic                      y_ready;
    logic [SEL_W-1:0]          y_chan;

    modport master (
        output in_data, in_valid, mode, sel, y_ready,
        input  in_ready, y, y_valid, y_chan
    );

    modport slave (
        input  in_data, in_valid, mode, sel, y_ready,
        output in_ready, y, y_valid, y_chan
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr -- N-to-1 registered channel multiplexer with manual or
// round-robin channel selection.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_nx1_rr_if.slave (inputs in_data/in_valid/mode/sel/y_ready,
//           outputs in_ready/y/y_valid/y_chan)
// The output register is a one-entry skid-less stage: it reloads whenever it
// is empty or being drained, so back-to-back words flow at one per cycle.
module mux_nx1_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nx1_rr_if.slave   bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    // Channel vectors are padded to a power of two so any SEL_W-bit index is
    // in range; padded channels read as never-valid, which is what makes an
    // out-of-range sel produce no grant.
    localparam int PAD = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] y_chan_q, y_chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [PAD-1:0]            valid_pad;
    logic [PAD-1:0][WIDTH-1:0] data_pad;
    logic [SEL_W-1:0]          grant;
    logic                      grant_valid;
    logic [SEL_W:0]            idx;
    logic                      load_en;
    logic                      xfer;

    generate
        for (genvar k = 0; k < PAD; k++) begin : g_pad
            if (k < CHANNELS) begin : g_live
                assign valid_pad[k] = bus.in_valid[k];
                assign data_pad[k]  = bus.in_data[k*WIDTH +: WIDTH];
            end else begin : g_dead
                assign valid_pad[k] = 1'b0;
                assign data_pad[k]  = '0;
            end
        end
    endgenerate

    // Grant selection. The round-robin scan walks offsets from the far end
    // back to ptr so the last assignment is the first valid channel at or
    // after ptr in circular order.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (!bus.mode) begin
            grant       = bus.sel;
            grant_valid = valid_pad[bus.sel];
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                idx = {1'b0, ptr_q} + (SEL_W+1)'(i);
                if (idx >= CH_N) idx = idx - CH_N;
                if (valid_pad[idx[SEL_W-1:0]]) begin
                    grant       = idx[SEL_W-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign load_en = (state_q == EMPTY) || bus.y_ready;
    // rst_n gating keeps in_ready low during reset even before state is known.
    assign xfer    = rst_n && load_en && grant_valid;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_rdy
            assign bus.in_ready[k] = xfer && (grant == SEL_W'(k));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        y_chan_d = y_chan_q;
        ptr_d    = ptr_q;
        if (xfer) begin
            state_d  = FULL;
            y_d      = data_pad[grant];
            y_chan_d = grant;
            if (bus.mode) ptr_d = (grant == LAST) ? '0 : grant + 1'b1;
        end else if (state_q == FULL && bus.y_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            y_q      <= '0;
            y_chan_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            y_chan_q <= y_chan_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = (state_q == FULL);
    assign bus.y_chan  = y_chan_q;
endmodule
